// File: rtl/icache_refill_engine_if.sv
// Bundle between the I-cache refill engine, fetch-data stage, memory bus and I-cache arrays.
// The master modport is the engine's view; slave is the surrounding pipeline/bus/arrays.
interface icache_refill_engine_if #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned NUM_SETS   = 64
);
  localparam int unsigned OFS_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = 30 - OFS_W - IDX_W;

  logic             miss_valid;
  logic [31:0]      miss_addr;
  logic             miss_ready;
  logic             inval_req;
  logic             mem_req_valid;
  logic [31:0]      mem_req_addr;
  logic             mem_req_ready;
  logic             mem_rsp_valid;
  logic [31:0]      mem_rsp_data;
  logic             fill_data_we;
  logic [IDX_W-1:0] fill_index;
  logic [OFS_W-1:0] fill_word;
  logic [31:0]      fill_data;
  logic             fill_tag_we;
  logic [TAG_W-1:0] fill_tag;
  logic             fill_tag_valid;
  logic             refill_done;
  logic             busy;

  modport master (
    input  miss_valid, miss_addr, inval_req, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output miss_ready, mem_req_valid, mem_req_addr, fill_data_we, fill_index, fill_word,
           fill_data, fill_tag_we, fill_tag, fill_tag_valid, refill_done, busy
  );

  modport slave (
    output miss_valid, miss_addr, inval_req, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  miss_ready, mem_req_valid, mem_req_addr, fill_data_we, fill_index, fill_word,
           fill_data, fill_tag_we, fill_tag, fill_tag_valid, refill_done, busy
  );
endinterface

// File: rtl/icache_refill_engine.sv
// I-cache line refill and invalidate-all sweep controller.
// Define ICACHE_CRITICAL_WORD_FIRST_EN for a wrapping, critical-word-first burst.
module icache_refill_engine #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned NUM_SETS   = 64
) (
  input logic                    clk,
  input logic                    rst,
  icache_refill_engine_if.master bus_io
);
  localparam int unsigned OFS_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = 30 - OFS_W - IDX_W;

  typedef enum logic [2:0] {StIdle, StInval, StReq, StFill, StDone} state_e;

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic [29:0]      addr_q, addr_d;
  logic [OFS_W-1:0] beat_q, beat_d;
  logic [IDX_W-1:0] inval_idx_q, inval_idx_d;
  logic             dwe_q, twe_q;
  logic [IDX_W-1:0] index_q;
  logic [OFS_W-1:0] word_q;
  logic [31:0]      data_q;
  logic [TAG_W-1:0] tag_q;

  logic             beat_acc, last_beat;
  logic [OFS_W-1:0] miss_ofs, beat_word;
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;
  logic [31:0]      req_addr;
  logic             unused_addr_lsbs;

  assign miss_ofs = addr_q[OFS_W-1:0];
  assign miss_idx = addr_q[OFS_W+IDX_W-1:OFS_W];
  assign miss_tag = addr_q[29:OFS_W+IDX_W];
  assign unused_addr_lsbs = ^bus_io.miss_addr[1:0];

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  assign req_addr  = {addr_q, 2'b00};
  assign beat_word = miss_ofs + beat_q;
`else
  logic unused_miss_ofs;
  assign unused_miss_ofs = ^miss_ofs;
  assign req_addr  = {addr_q[29:OFS_W], {OFS_W{1'b0}}, 2'b00};
  assign beat_word = beat_q;
`endif

  // twe_q marks the cycle the last word and tag are written; later beats are not ours.
  assign beat_acc  = (state_q == StFill) && bus_io.mem_rsp_valid && !twe_q;
  assign last_beat = (beat_q == OFS_W'(LINE_WORDS - 1));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    beat_d      = beat_q;
    inval_idx_d = inval_idx_q;
    pend_d      = pend_q | (bus_io.inval_req && (state_q inside {StReq, StFill, StDone}));
    unique case (state_q)
      StIdle: begin
        if (bus_io.inval_req || pend_q) begin
          state_d     = StInval;
          pend_d      = 1'b0;
          inval_idx_d = '0;
        end else if (bus_io.miss_valid) begin
          state_d = StReq;
          addr_d  = bus_io.miss_addr[31:2];
        end
      end
      StInval: begin
        if (bus_io.inval_req) begin
          inval_idx_d = '0;
        end else if (inval_idx_q == IDX_W'(NUM_SETS - 1)) begin
          state_d = StDone;
        end else begin
          inval_idx_d = inval_idx_q + 1'b1;
        end
      end
      StReq: begin
        if (bus_io.mem_req_ready) begin
          state_d = StFill;
          beat_d  = '0;
        end
      end
      StFill: begin
        if (beat_acc) beat_d = beat_q + 1'b1;
        if (twe_q) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      pend_q      <= 1'b0;
      addr_q      <= '0;
      beat_q      <= '0;
      inval_idx_q <= '0;
      dwe_q       <= 1'b0;
      twe_q       <= 1'b0;
      index_q     <= '0;
      word_q      <= '0;
      data_q      <= '0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      addr_q      <= addr_d;
      beat_q      <= beat_d;
      inval_idx_q <= inval_idx_d;
      dwe_q       <= beat_acc;
      twe_q       <= beat_acc && last_beat;
      if (beat_acc) begin
        index_q <= miss_idx;
        word_q  <= beat_word;
        data_q  <= bus_io.mem_rsp_data;
        tag_q   <= miss_tag;
      end
    end
  end

  // A fresh invalidate pulse must also block acceptance so a simultaneous miss is held.
  assign bus_io.miss_ready     = (state_q == StIdle) && !pend_q && !bus_io.inval_req;
  assign bus_io.mem_req_valid  = (state_q == StReq);
  assign bus_io.mem_req_addr   = req_addr;
  assign bus_io.fill_data_we   = dwe_q;
  assign bus_io.fill_word      = word_q;
  assign bus_io.fill_data      = data_q;
  assign bus_io.fill_index     = (state_q == StInval) ? inval_idx_q : index_q;
  assign bus_io.fill_tag_we    = (state_q == StInval) || twe_q;
  assign bus_io.fill_tag       = (state_q == StInval) ? '0 : tag_q;
  assign bus_io.fill_tag_valid = twe_q;
  assign bus_io.refill_done    = (state_q == StDone);
  assign bus_io.busy           = (state_q != StIdle);
endmodule

// File: tb/tb_icache_refill_engine.sv
// Directed self-checking bench for icache_refill_engine (LINE_WORDS=8, NUM_SETS=64).
module tb_icache_refill_engine;
  localparam int unsigned LW = 8;
  localparam int unsigned NS = 64;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  localparam bit Cwf = 1'b1;
`else
  localparam bit Cwf = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  icache_refill_engine_if #(.LINE_WORDS(LW), .NUM_SETS(NS)) bus ();
  icache_refill_engine #(.LINE_WORDS(LW), .NUM_SETS(NS)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0, n_dwe = 0, n_tv = 0, n_inv = 0, n_done = 0, n_hs = 0;
  int n_reqv = 0, n_unstable = 0, n_mr = 0, n_order = 0;
  int last_beat_cyc = 0, tv_cyc = 0, done_cyc = 0, inv_last_cyc = 0, hs_cyc = 0;
  int prev_inv = -1;
  logic [31:0] hs_addr = '0, prev_req_addr = '0;
  logic        prev_req_pend = 1'b0;
  logic [5:0]  last_idx = '0, last_inv_idx = '0;
  logic [20:0] last_tag = '0;
  logic [31:0] mem_word [LW];

  // Event monitor: sees the values of the cycle that ends at this edge.
  always @(posedge clk) begin
    if (bus.mem_rsp_valid) last_beat_cyc = cyc;
    if (bus.fill_data_we) begin
      n_dwe++;
      mem_word[bus.fill_word] = bus.fill_data;
      last_idx = bus.fill_index;
    end
    if (bus.fill_tag_we && bus.fill_tag_valid) begin
      n_tv++;
      tv_cyc   = cyc;
      last_tag = bus.fill_tag;
    end
    if (bus.fill_tag_we && !bus.fill_tag_valid) begin
      n_inv++;
      inv_last_cyc = cyc;
      last_inv_idx = bus.fill_index;
      if (bus.fill_index != 6'd0 && int'(bus.fill_index) != prev_inv + 1) n_order++;
      prev_inv = int'(bus.fill_index);
    end
    if (bus.refill_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (bus.miss_ready) n_mr++;
    if (bus.mem_req_valid) begin
      n_reqv++;
      if (prev_req_pend && bus.mem_req_addr != prev_req_addr) n_unstable++;
      if (bus.mem_req_ready) begin
        n_hs++;
        hs_addr = bus.mem_req_addr;
        hs_cyc  = cyc;
      end
    end
    prev_req_pend = bus.mem_req_valid && !bus.mem_req_ready;
    prev_req_addr = bus.mem_req_addr;
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_miss(input logic [31:0] addr, input bit with_inval);
    bus.miss_valid = 1'b1;
    bus.miss_addr  = addr;
    bus.inval_req  = with_inval;
    if (with_inval) begin
      #1;
      check("miss_ready_masked_by_inval", bus.miss_ready, 0);
      step();
      bus.inval_req = 1'b0;
    end
    for (int t = 0; t < 200 && !bus.miss_ready; t++) step();
    check("miss_accept", bus.miss_ready, 1);
    step();
    bus.miss_valid = 1'b0;
  endtask

  task automatic serve(input int rdy_delay, input int gap_max, input int beats,
                       input int inval_at, input logic [31:0] base);
    for (int t = 0; t < 50 && !bus.mem_req_valid; t++) step();
    check("req_valid_seen", bus.mem_req_valid, 1);
    repeat (rdy_delay) step();
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < beats; i++) begin
      repeat ($urandom_range(gap_max, 0)) step();
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = base + i;
      bus.inval_req     = (i == inval_at);
      step();
      bus.mem_rsp_valid = 1'b0;
      bus.inval_req     = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag, input int base, input int need);
    for (int t = 0; t < 300 && (n_done - base) < need; t++) step();
    check(tag, n_done - base, need);
  endtask

  task automatic check_line(input string tag, input logic [31:0] base, input int ofs);
    int bad = 0;
    for (int w = 0; w < int'(LW); w++)
      if (mem_word[w] !== base + ((w - ofs) & (LW - 1))) bad++;
    check(tag, bad, 0);
  endtask

  int b_dwe, b_hs, b_done, b_tv, b_inv, b_order, b_mr, b_reqv, b_unst;

  task automatic snap();
    b_dwe = n_dwe; b_hs = n_hs; b_done = n_done; b_tv = n_tv; b_inv = n_inv;
    b_order = n_order; b_mr = n_mr; b_reqv = n_reqv; b_unst = n_unstable;
  endtask

  initial begin
    bus.miss_valid = 1'b0; bus.miss_addr = '0; bus.inval_req = 1'b0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_miss_ready", bus.miss_ready, 1);
    check("rst_strobes", {bus.busy, bus.mem_req_valid, bus.fill_data_we, bus.fill_tag_we,
                          bus.fill_tag_valid, bus.refill_done}, 0);
    check("rst_req_addr", bus.mem_req_addr, 0);
    check("rst_fill_fields", {bus.fill_index, bus.fill_word, bus.fill_tag}, 0);
    check("rst_fill_data", bus.fill_data, 0);
    rst = 1'b1;
    step();

    // Basic refill at 0x44: index 2, offset 1, tag 0.
    snap();
    do_miss(32'h44, 1'b0);
    serve(0, 0, 8, -1, 32'hA0);
    wait_done("t1_done", b_done, 1);
    check("t1_ready_after", bus.miss_ready, 1);
    check("t1_req_addr", hs_addr, Cwf ? 32'h44 : 32'h40);
    check("t1_handshakes", n_hs - b_hs, 1);
    check("t1_data_writes", n_dwe - b_dwe, 8);
    check("t1_index", last_idx, 2);
    check_line("t1_words", 32'hA0, Cwf ? 1 : 0);
    check("t1_tag", last_tag, 0);
    check("t1_tag_writes", n_tv - b_tv, 1);
    check("t1_tag_latency", tv_cyc - last_beat_cyc, 1);
    check("t1_done_latency", done_cyc - last_beat_cyc, 2);
    step(); step();
    check("t1_single_done", n_done - b_done, 1);

    // Bus stalls the request 5 cycles: 0x1A64 -> index 19, offset 1, tag 3.
    snap();
    do_miss(32'h1A64, 1'b0);
    serve(5, 0, 8, -1, 32'h10);
    wait_done("t2_done", b_done, 1);
    check("t2_req_stable", n_unstable - b_unst, 0);
    check("t2_req_valid_cycles", n_reqv - b_reqv, 6);
    check("t2_handshakes", n_hs - b_hs, 1);
    check("t2_req_addr", hs_addr, Cwf ? 32'h1A64 : 32'h1A60);
    check("t2_index", last_idx, 19);
    check("t2_tag", last_tag, 3);
    check_line("t2_words", 32'h10, Cwf ? 1 : 0);

    // Random beat gaps at the top of memory: index 63, offset 7, tag all ones.
    snap();
    do_miss(32'hFFFF_FFFC, 1'b0);
    serve(0, 3, 8, -1, 32'h5A0);
    wait_done("t3_done", b_done, 1);
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hDEAD;
    step(); step();
    bus.mem_rsp_valid = 1'b0;
    step(); step();
    check("t3_data_writes", n_dwe - b_dwe, 8);
    check("t3_req_addr", hs_addr, Cwf ? 32'hFFFF_FFFC : 32'hFFFF_FFE0);
    check("t3_index", last_idx, 63);
    check("t3_tag", last_tag, 21'h1F_FFFF);
    check_line("t3_words", 32'h5A0, Cwf ? 7 : 0);

    // Invalidate during beat 3: refill finishes, then the full sweep.
    snap();
    do_miss(32'h44, 1'b0);
    b_mr = n_mr;
    serve(0, 0, 8, 3, 32'hC0);
    wait_done("t4_done", b_done, 2);
    check("t4_data_writes", n_dwe - b_dwe, 8);
    check("t4_tag_valid_writes", n_tv - b_tv, 1);
    check_line("t4_words", 32'hC0, Cwf ? 1 : 0);
    check("t4_inval_writes", n_inv - b_inv, 64);
    check("t4_inval_order", n_order - b_order, 0);
    check("t4_inval_last_idx", last_inv_idx, 63);
    check("t4_done_after_sweep", done_cyc - inv_last_cyc, 1);
    check("t4_miss_ready_low", n_mr - b_mr, 0);

    // Invalidate and miss together in IDLE: 0x20088 -> index 4, offset 2, tag 64.
    snap();
    do_miss(32'h0002_0088, 1'b1);
    check("t5_sweep_before_accept", n_inv - b_inv, 64);
    serve(0, 1, 8, -1, 32'h7700);
    wait_done("t5_done", b_done, 2);
    check("t5_miss_after_sweep", hs_cyc > inv_last_cyc, 1);
    check("t5_req_addr", hs_addr, Cwf ? 32'h0002_0088 : 32'h0002_0080);
    check("t5_data_writes", n_dwe - b_dwe, 8);
    check("t5_index", last_idx, 4);
    check("t5_tag", last_tag, 64);
    check_line("t5_words", 32'h7700, Cwf ? 2 : 0);

    // Reset in the middle of a fill, then stray beats.
    do_miss(32'h44, 1'b0);
    serve(0, 0, 3, -1, 32'hE0);
    rst = 1'b0;
    #1;
    check("t6_rst_strobes", {bus.busy, bus.mem_req_valid, bus.fill_data_we, bus.fill_tag_we,
                             bus.refill_done}, 0);
    check("t6_rst_miss_ready", bus.miss_ready, 1);
    check("t6_rst_buses", bus.fill_data | bus.mem_req_addr, 0);
    step(); step();
    rst = 1'b1;
    snap();
    for (int i = 0; i < 4; i++) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'hBAD0 + i;
      step();
    end
    bus.mem_rsp_valid = 1'b0;
    step(); step();
    check("t6_stray_writes", n_dwe - b_dwe, 0);
    check("t6_idle", bus.busy, 0);
    do_miss(32'h44, 1'b0);
    serve(0, 0, 8, -1, 32'h300);
    wait_done("t6_done", b_done, 1);
    check("t6_data_writes", n_dwe - b_dwe, 8);
    check_line("t6_words", 32'h300, Cwf ? 1 : 0);
    check("t6_tag_writes", n_tv - b_tv, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
